// File: rtl/seq_pkg.sv
// Shared types and constants for the word serializer.
//   seq_state_t        : shifter state (idle / shifting a word out)
//   SEQ_DEFAULT_WIDTH  : default parallel word width
package seq_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } seq_state_t;

    localparam int SEQ_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/seq_sync_fifo.sv
// Small synchronous FIFO feeding the serializer's shifter.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   clr            : synchronous clear (empties the FIFO, wins over write)
//   wr_en, wr_data : write request/data, ignored when full
//   rd_en          : pop the head, ignored when empty
//   rd_data        : combinational head word
//   full, empty    : occupancy flags
//   level          : occupancy count, 0..DEPTH
module seq_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_LVL);
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];
    assign level   = count;

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/seq_word_serializer.sv
// Parallel-to-serial feeder for the serial pattern detector. Words arrive
// over valid/ready into a small FIFO and leave one bit per enabled cycle on
// a registered serial line. Consecutive words are sent with no idle bit.
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   flush                : synchronous clear of FIFO and shifter
//   in_data, in_valid    : parallel word and its valid
//   in_ready             : FIFO not full (does not consider a same-cycle pop)
//   out_en               : downstream advance enable, 0 stalls the shifter
//   seq, seq_valid       : registered serial bit and its qualifier
//   busy                 : FIFO non-empty or a word is being shifted
//   fifo_level           : FIFO occupancy
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no word in the shifter, seq=0/seq_valid=0, loads when FIFO non-empty
// ST_SHIFT | word in flight, bit_cnt = bits left including the one on seq
module seq_word_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SEQ_DEFAULT_WIDTH,
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     out_en,
    output logic                     seq,
    output logic                     seq_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);

    seq_state_t       state;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    bit_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             last_bit;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Moves the next bit to send into the position first_bit() reads.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign in_ready = !full;
    // A write coinciding with flush is dropped even though in_ready is high.
    assign push     = in_valid && !full && !flush;
    assign last_bit = (bit_cnt == CW'(1));
    assign busy     = (fifo_level != '0) || (state == ST_SHIFT);

    always_comb begin
        pop = 1'b0;
        if (!flush && !empty) begin
            if (state == ST_IDLE) begin
                pop = 1'b1;
            end else if (out_en && last_bit) begin
                pop = 1'b1;
            end
        end
    end

    seq_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .wr_en   (push),
        .wr_data (in_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            seq       <= 1'b0;
            seq_valid <= 1'b0;
        end else if (flush) begin
            state     <= ST_IDLE;
            sreg      <= '0;
            bit_cnt   <= '0;
            seq       <= 1'b0;
            seq_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        sreg      <= advance(head);
                        seq       <= first_bit(head);
                        seq_valid <= 1'b1;
                        bit_cnt   <= CNT_LOAD;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (out_en) begin
                        if (!last_bit) begin
                            seq     <= first_bit(sreg);
                            sreg    <= advance(sreg);
                            bit_cnt <= bit_cnt - 1'b1;
                        end else if (pop) begin
                            // Reload on the last-bit edge keeps the stream gapless.
                            sreg    <= advance(head);
                            seq     <= first_bit(head);
                            bit_cnt <= CNT_LOAD;
                        end else begin
                            seq       <= 1'b0;
                            seq_valid <= 1'b0;
                            bit_cnt   <= '0;
                            state     <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
